ritc_bit_control_arbiter: RTL and testbench

- Generates the serial `bit_control` stream that configures every per-bit IDELAY value, IDELAY load and ISERDES bitslip in the dual-RITC datapath.
- Two requesters share the one serial line: the user register interface and the automatic eye-training sequencer. The block arbitrates between them round-robin.
- Each accepted command is serialized as one framed word.
- Runs in the user clock domain and replaces the direct register-to-`ctrl_o` path.

---
 rtl/ritc_ctrl_pkg.sv | 43 ++++
 rtl/ritc_bit_control_arbiter_if.sv | 21 ++
 rtl/ritc_ctrl_frame_shifter.sv | 39 +++
 rtl/ritc_bit_control_arbiter.sv | 116 +++++++++++
 tb/tb_ritc_bit_control_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ritc_ctrl_pkg.sv
// Shared constants, state encoding and frame builder for the bit_control arbiter.
// Build option RITC_CTRL_PARITY_EN inserts an even-parity bit ahead of the stop bit.
package ritc_ctrl_pkg;

  localparam int CMD_W   = 14;
  localparam int CH_LSB  = 11;
  localparam int BIT_LSB = 7;
  localparam int DLY_LSB = 2;
  localparam int LOAD    = 1;
  localparam int SLIP    = 0;

  localparam int FRAME_LEN_BASE   = 16;
  localparam int FRAME_LEN_PARITY = 17;
`ifdef RITC_CTRL_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int FRAME_LEN = PARITY_EN ? FRAME_LEN_PARITY : FRAME_LEN_BASE;

  localparam logic [2:0] CH_ILLEGAL_A = 3'd3;
  localparam logic [2:0] CH_ILLEGAL_B = 3'd7;

  typedef enum logic [1:0] {FLUSH, IDLE, SHIFT, GUARD} state_t;
  typedef enum logic {GNT_USER, GNT_TRAIN} grant_t;

  function automatic logic ch_illegal(input logic [CMD_W-1:0] cmd);
    logic [2:0] ch;
    ch = cmd[CH_LSB +: 3];
    return (ch == CH_ILLEGAL_A) || (ch == CH_ILLEGAL_B);
  endfunction

  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [CMD_W-1:0] cmd);
    logic [CMD_W-1:0] payload;
    payload = {cmd[CH_LSB +: 3], cmd[BIT_LSB +: 4], cmd[DLY_LSB +: 5], cmd[LOAD], cmd[SLIP]};
`ifdef RITC_CTRL_PARITY_EN
    return {1'b1, payload, ^payload, 1'b1};
`else
    return {1'b1, payload, 1'b1};
`endif
  endfunction

endpackage

// File: rtl/ritc_bit_control_arbiter_if.sv
// Request/command/ack handshake for the user and training requesters.
interface ritc_bit_control_arbiter_if;
  import ritc_ctrl_pkg::*;

  logic             user_req_i;
  logic [CMD_W-1:0] user_cmd_i;
  logic             user_ack_o;
  logic             train_req_i;
  logic [CMD_W-1:0] train_cmd_i;
  logic             train_ack_o;

  modport master (
    output user_req_i, user_cmd_i, train_req_i, train_cmd_i,
    input  user_ack_o, train_ack_o
  );

  modport slave (
    input  user_req_i, user_cmd_i, train_req_i, train_cmd_i,
    output user_ack_o, train_ack_o
  );
endinterface

// File: rtl/ritc_ctrl_frame_shifter.sv
// MSB-first serializer for one bit_control frame; done is high while the stop bit is on the line.
module ritc_ctrl_frame_shifter
  import ritc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [FRAME_LEN-1:0] frame,
  output logic                 ser,
  output logic                 done
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  logic [FRAME_LEN-1:0] sr;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 active;

  // Zeros shift in behind the frame, so the line idles low with no extra mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
    end else if (load) begin
      sr      <= frame;
      bit_cnt <= CNT_W'(FRAME_LEN - 1);
      active  <= 1'b1;
    end else if (active) begin
      sr <= {sr[FRAME_LEN-2:0], 1'b0};
      if (bit_cnt == '0) active <= 1'b0;
      else bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign ser  = sr[FRAME_LEN-1];
  assign done = active && (bit_cnt == '0);

endmodule

// File: rtl/ritc_bit_control_arbiter.sv
// Round-robin arbiter between user and training requesters driving the serial bit_control line.
// Build option RITC_CTRL_PARITY_EN selects the 17-bit parity frame (see ritc_ctrl_pkg).
module ritc_bit_control_arbiter
  import ritc_ctrl_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int FLUSH_CYCLES = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  ritc_bit_control_arbiter_if.slave  bus,
  output logic                       ctrl_o,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [15:0]                frame_count_o
);

  state_t         state;
  grant_t         last_grant;
  logic [7:0]     flush_cnt;
  logic [3:0]     guard_cnt;
  logic [15:0]    frame_cnt;
  logic           user_ack, train_ack, err, busy;

  logic                 req_any, pick_user, sel_illegal, load, shift_done;
  logic [CMD_W-1:0]     sel_cmd;
  logic [FRAME_LEN-1:0] frame_in;

  always_comb begin
    req_any     = bus.user_req_i | bus.train_req_i;
    pick_user   = bus.user_req_i & (~bus.train_req_i | (last_grant == GNT_TRAIN));
    sel_cmd     = pick_user ? bus.user_cmd_i : bus.train_cmd_i;
    sel_illegal = ch_illegal(sel_cmd);
    load        = (state == IDLE) & req_any & ~sel_illegal;
    frame_in    = build_frame(sel_cmd);
  end

  ritc_ctrl_frame_shifter u_shifter (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (load),
    .frame (frame_in),
    .ser   (ctrl_o),
    .done  (shift_done)
  );

  // The IDLE sampling cycle is itself a low cycle, so GUARD holds GUARD_CYCLES-1 cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= FLUSH;
      last_grant <= GNT_TRAIN;
      flush_cnt  <= 8'(FLUSH_CYCLES - 1);
      guard_cnt  <= '0;
      frame_cnt  <= '0;
      user_ack   <= 1'b0;
      train_ack  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b1;
    end else begin
      user_ack  <= 1'b0;
      train_ack <= 1'b0;
      err       <= 1'b0;
      case (state)
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        IDLE: begin
          if (req_any) begin
            last_grant <= pick_user ? GNT_USER : GNT_TRAIN;
            user_ack   <= pick_user;
            train_ack  <= ~pick_user;
            if (sel_illegal) begin
              err <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (shift_done) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (GUARD_CYCLES == 1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= GUARD;
              guard_cnt <= 4'(GUARD_CYCLES - 2);
            end
          end
        end
        GUARD: begin
          if (guard_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

  assign bus.user_ack_o  = user_ack;
  assign bus.train_ack_o = train_ack;
  assign busy_o          = busy;
  assign err_o           = err;
  assign frame_count_o   = frame_cnt;

endmodule

// File: tb/tb_ritc_bit_control_arbiter.sv
// Directed bench for ritc_bit_control_arbiter with a downstream frame decoder on ctrl_o.
module tb_ritc_bit_control_arbiter;

`ifdef RITC_CTRL_PARITY_EN
  localparam int FL = 17;
  localparam logic [FL-1:0] FRAME_A = 17'b10010101100111011;
  localparam logic [FL-1:0] FRAME_P = 17'b10000000000000111;
`else
  localparam int FL = 16;
  localparam logic [FL-1:0] FRAME_A = 16'b1001010110011101;
  localparam logic [FL-1:0] FRAME_P = 16'b1000000000000011;
`endif
  localparam logic [13:0] CMD_A = 14'h0ACE;
  localparam logic [13:0] CMD_P = 14'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl, busy, err;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;

  ritc_bit_control_arbiter_if bus ();

  ritc_bit_control_arbiter #(.GUARD_CYCLES(2), .FLUSH_CYCLES(20)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .ctrl_o        (ctrl),
    .busy_o        (busy),
    .err_o         (err),
    .frame_count_o (frame_count)
  );

  always #5 clk = ~clk;

  // Downstream decoder: commits only with stop=1 (and good parity when enabled).
  logic [FL-1:0] dec_sr;
  logic [13:0]   dec_payload;
  logic [13:0]   dec_word = '0;
  logic          dec_ok;
  logic          dec_flip = 1'b0;
  int            dec_n = 0;
  int            dec_commits = 0;
  int            dec_rejects = 0;

  always @(negedge clk) begin
    if (dec_n == 0) begin
      if (ctrl === 1'b1) begin
        dec_sr    = '0;
        dec_sr[0] = 1'b1;
        dec_n     = 1;
      end
    end else begin
      dec_sr = {dec_sr[FL-2:0], ctrl ^ (dec_flip && dec_n == 5)};
      dec_n  = dec_n + 1;
      if (dec_n == FL) begin
        dec_n       = 0;
        dec_payload = dec_sr[FL-2 -: 14];
        dec_ok      = dec_sr[0];
`ifdef RITC_CTRL_PARITY_EN
        dec_ok = dec_ok && (dec_sr[1] == ^dec_payload);
`endif
        if (dec_ok) begin
          dec_commits++;
          dec_word = dec_payload;
        end else begin
          dec_rejects++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] mk_cmd(input logic [2:0] ch, input logic [3:0] b,
                                         input logic [4:0] dly, input logic ld, input logic sl);
    return {ch, b, dly, ld, sl};
  endfunction

  function automatic logic [FL-1:0] mk_frame(input logic [13:0] c);
`ifdef RITC_CTRL_PARITY_EN
    return {1'b1, c, ^c, 1'b1};
`else
    return {1'b1, c, 1'b1};
`endif
  endfunction

  // Current sample holds the start bit; returns on the stop-bit sample.
  task automatic recv_frame(output logic [FL-1:0] f);
    f[FL-1] = ctrl;
    for (int i = FL - 2; i >= 0; i--) begin
      step();
      f[i] = ctrl;
    end
  endtask

  // From the stop-bit sample, count low cycles until the next start bit.
  task automatic wait_start(output int gap);
    gap = 0;
    step();
    while (ctrl !== 1'b1 && gap < 40) begin
      gap++;
      step();
    end
  endtask

  logic [FL-1:0] f;
  logic [13:0]   cmd_b, cmd_c, cmd_d;
  int            gap, bad;

  initial begin
    cmd_b = mk_cmd(3'd2, 4'd14, 5'h05, 1'b0, 1'b1);
    cmd_c = mk_cmd(3'd6, 4'd15, 5'h1F, 1'b1, 1'b1);
    cmd_d = mk_cmd(3'd0, 4'd11, 5'h00, 1'b0, 1'b0);
    rst = 1'b1;
    bus.user_req_i  = 1'b0;
    bus.user_cmd_i  = '0;
    bus.train_req_i = 1'b0;
    bus.train_cmd_i = '0;
    repeat (3) step();
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_ack_err", 32'({bus.user_ack_o, bus.train_ack_o, err}), 32'd0);

    // Both requests pending through flush; user wins the first tie.
    rst = 1'b0;
    bus.user_req_i  = 1'b1;
    bus.user_cmd_i  = CMD_A;
    bus.train_req_i = 1'b1;
    bus.train_cmd_i = cmd_b;
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ctrl !== 1'b0 || bus.user_ack_o !== 1'b0 || bus.train_ack_o !== 1'b0) bad++;
      if (i < 20 && busy !== 1'b1) bad++;
    end
    check("flush_quiet", 32'(bad), 32'd0);
    check("flush_end_busy", 32'(busy), 32'd0);
    step();
    check("tie_user_ack", 32'(bus.user_ack_o), 32'd1);
    check("tie_train_noack", 32'(bus.train_ack_o), 32'd0);
    check("start_bit", 32'(ctrl), 32'd1);
    bus.user_req_i = 1'b0;
    recv_frame(f);
    check("frame_a", 32'(f), 32'(FRAME_A));
    wait_start(gap);
    check("gap_a_b", 32'(gap), 32'd2);
    check("train_ack_second", 32'(bus.train_ack_o), 32'd1);
    check("count_after_a", 32'(frame_count), 32'd1);
    bus.train_req_i = 1'b0;
    recv_frame(f);
    check("frame_b", 32'(f), 32'(mk_frame(cmd_b)));
    step();
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("count_after_b", 32'(frame_count), 32'd2);

    // Illegal channels: ack + err, no frame, last_grant still moves.
    bus.train_req_i = 1'b1;
    bus.train_cmd_i = mk_cmd(3'd3, 4'd2, 5'h04, 1'b1, 1'b0);
    step();
    check("ill3_ack_err", 32'({bus.train_ack_o, err, ctrl, busy}), 32'b1100);
    bus.train_req_i = 1'b0;
    step();
    check("ill3_after", 32'({bus.train_ack_o, err, ctrl}), 32'd0);
    check("ill3_count", 32'(frame_count), 32'd2);
    bus.user_req_i = 1'b1;
    bus.user_cmd_i = mk_cmd(3'd7, 4'd0, 5'h00, 1'b0, 1'b0);
    step();
    check("ill7_ack_err", 32'({bus.user_ack_o, bus.train_ack_o, err, ctrl}), 32'b1010);
    bus.user_req_i  = 1'b1;
    bus.user_cmd_i  = cmd_c;
    bus.train_req_i = 1'b1;
    bus.train_cmd_i = cmd_d;
    step();
    check("tie2_train_first", 32'({bus.user_ack_o, bus.train_ack_o, err}), 32'b010);
    bus.train_req_i = 1'b0;
    recv_frame(f);
    check("frame_d", 32'(f), 32'(mk_frame(cmd_d)));
    wait_start(gap);
    check("gap_d_c", 32'(gap), 32'd2);
    check("tie2_user_second", 32'(bus.user_ack_o), 32'd1);
    bus.user_req_i = 1'b0;
    recv_frame(f);
    check("frame_c", 32'(f), 32'(mk_frame(cmd_c)));
    step();
    step();
    check("count_after_c", 32'(frame_count), 32'd4);
    check("dec_commits_4", 32'(dec_commits), 32'd4);
    check("dec_word_c", 32'(dec_word), 32'(cmd_c));

    // Reset while bit 7 of frame A is on the line.
    bus.user_req_i = 1'b1;
    bus.user_cmd_i = CMD_A;
    step();
    check("mid_ack", 32'(bus.user_ack_o), 32'd1);
    bus.user_req_i = 1'b0;
    repeat (7) step();
    check("mid_bit7", 32'(ctrl), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", 32'(ctrl), 32'd0);
    check("mid_rst_state", 32'({busy, bus.user_ack_o, bus.train_ack_o, err}), 32'b1000);
    check("mid_rst_count", 32'(frame_count), 32'd0);
    step();
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ctrl !== 1'b0) bad++;
      if (i < 20 && busy !== 1'b1) bad++;
    end
    check("reflush_quiet", 32'(bad), 32'd0);
    check("reflush_end_busy", 32'(busy), 32'd0);
    check("dec_no_commit", 32'(dec_commits), 32'd4);
    check("dec_reject_partial", 32'(dec_rejects), 32'd1);

    // Counter wrap.
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    check("preload", 32'(frame_count), 32'hFFFF);
    bus.user_req_i = 1'b1;
    bus.user_cmd_i = CMD_P;
    step();
    check("wrap_ack", 32'(bus.user_ack_o), 32'd1);
    bus.user_req_i = 1'b0;
    recv_frame(f);
    check("frame_p", 32'(f), 32'(FRAME_P));
    step();
    check("count_wrap", 32'(frame_count), 32'h0000);
    step();
    step();
    check("dec_commit_p", 32'(dec_commits), 32'd5);
    check("dec_word_p", 32'(dec_word), 32'(CMD_P));

`ifdef RITC_CTRL_PARITY_EN
    dec_flip = 1'b1;
    bus.user_req_i = 1'b1;
    bus.user_cmd_i = CMD_P;
    step();
    bus.user_req_i = 1'b0;
    recv_frame(f);
    check("frame_p2", 32'(f), 32'(FRAME_P));
    step();
    step();
    step();
    check("par_reject", 32'(dec_rejects), 32'd2);
    check("par_no_commit", 32'(dec_commits), 32'd5);
    dec_flip = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
